load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Data-memory access stage for the NPC core; produces mem_output for the writeback mux (WBSel = WRITEBACK_FROM_MEM).
//  Accepts one load/store per request handshake and drives a word-aligned valid/ready data-memory port.
//  For stores, it generates lane replication and a byte mask; for loads, it extracts and sign/zero-extends the result.
//  Holds at most one transaction; in-flight responses are bounded by a timeout counter.
// PARAMETERS
//  RESP_TIMEOUT  255  Max WAIT-state cycles before a bus error is reported; 1..255.
// PORTS
//  clk             in   1   core clock; all state on posedge
//  rst             in   1   asynchronous, active-high reset
//  req_valid       in   1   EXU presents an access
//  req_ready       out  1   LSU can accept; 1 only in IDLE
//  mem_wen         in   1   1 = store, 0 = load
//  mem_funct3      in   3   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr            in   32  byte address (ALU result)
//  wdata           in   32  store data (rs2)
//  resp_valid      out  1   one-cycle pulse; result/status valid
//  mem_output      out  32  extended load data; 0 for stores/errors
//  bus_err         out  1   timeout or illegal funct3, qualified by resp_valid
//  misalign        out  1   misaligned access, qualified by resp_valid (see CONFIGURATION)
//  dmem_req_valid  out  1   memory request
//  dmem_req_ready  in   1   memory accepts request
//  dmem_addr       out  32  {addr[31:2],2'b00}
//  dmem_wen        out  1   write request
//  dmem_wmask      out  4   byte-lane mask
//  dmem_wdata      out  32  lane-replicated store data
//  dmem_rvalid     in   1   read data / write ack
//  dmem_rdata      in   32  read word
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; timeout counter=0. Asserting rst mid-transaction aborts immediately,
//   dropping dmem_req_valid asynchronously; any later dmem_rvalid is ignored in IDLE.
//  FSM:
//   IDLE -(req_valid)-> REQ: latches addr/wdata/funct3/wen.
//   IDLE -(req_valid & fault)-> RESP: fault = illegal funct3 or misalign; no memory request issued.
//   REQ: dmem_req_valid=1 and request fields held stable until dmem_req_ready; then -> WAIT with counter cleared.
//   WAIT: on dmem_rvalid -> RESP (latch rdata). If the counter reaches RESP_TIMEOUT -> RESP with bus_err=1.
//    If both occur in the same cycle, rvalid wins.
//   RESP: resp_valid=1 for exactly one cycle -> IDLE. req_ready rises in the following cycle.
//  Min latency with a zero-wait memory: accept -> resp_valid = 3 cycles.
//  Stores also wait for dmem_rvalid, which acts as the write acknowledge.
//  Store lanes, with off = addr[1:0]:
//   SB: wdata={4{b}}, wmask = 4'b0001 << off
//   SH: wdata={2{h}}, wmask = 4'b0011 << {off[1],1'b0}
//   SW: wmask = 4'hF
//  Loads: dmem_wmask=0. Extract rdata >> (8*off) for bytes and rdata >> (16*off[1]) for halves,
//   then sign-extend (B, H) or zero-extend (BU, HU).
//  mem_output holds its value until the next resp_valid. Every error forces mem_output=0.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined:
//   H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, skips memory and responds with misalign=1, mem_output=0.
//  LSU_MISALIGN_CHECK_EN undefined:
//   misalign is tied 0; offending low address bits are ignored (half uses off[1], word uses offset 0).
// STRUCTURE
//  defines.vh additions: MEM_FUNCT3_{B,H,W,BU,HU} encodings and LSU state encodings (IDLE, REQ, WAIT, RESP).
//  One sub-module, load_extend: combinational rdata/offset/funct3 -> 32-bit result, built on MuxKeyWithDefault.
// TESTING
//  1. LW addr=0x80000004, rdata=0xDEADBEEF, ready/rvalid immediate -> mem_output=0xDEADBEEF, resp 3 cycles after accept.
//  2. LB addr=...03, rdata=0x80FF7F01 -> 0xFFFFFF80; LBU -> 0x00000080; LHU addr=...02 -> 0x000080FF.
//  3. SB addr=...02, wdata=0x000000AB -> dmem_wdata=0xABABABAB, wmask=4'b0100, dmem_addr low bits 00.
//  4. dmem_req_ready held low 5 cycles -> request fields stable throughout; rvalid never arrives
//     -> bus_err pulse after RESP_TIMEOUT WAIT cycles.
//  5. LW addr=...02 -> with LSU_MISALIGN_CHECK_EN: misalign=1, no dmem_req_valid;
//     without it: access goes to word ...00, misalign=0.
//  6. rst asserted during WAIT, then a stray dmem_rvalid -> outputs 0, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: RV32 memory funct3 values, FSM states,
// and small decode helpers for legality and alignment of an access.
// Latency: n/a (types/functions only). Backpressure: n/a.
package load_store_unit_pkg;

  localparam logic [2:0] MEM_FUNCT3_B  = 3'b000;
  localparam logic [2:0] MEM_FUNCT3_H  = 3'b001;
  localparam logic [2:0] MEM_FUNCT3_W  = 3'b010;
  localparam logic [2:0] MEM_FUNCT3_BU = 3'b100;
  localparam logic [2:0] MEM_FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_t;

  // Stores only have B/H/W forms; loads add the unsigned B/H variants.
  function automatic logic funct3_legal(input logic wen, input logic [2:0] funct3);
    logic ok;
    ok = (funct3 == MEM_FUNCT3_B) || (funct3 == MEM_FUNCT3_H) || (funct3 == MEM_FUNCT3_W);
    if (!wen) begin
      ok = ok || (funct3 == MEM_FUNCT3_BU) || (funct3 == MEM_FUNCT3_HU);
    end
    return ok;
  endfunction

  function automatic logic access_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if ((funct3 == MEM_FUNCT3_H) || (funct3 == MEM_FUNCT3_HU)) begin
      mis = off[0];
    end else if (funct3 == MEM_FUNCT3_W) begin
      mis = (off != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load result extraction: selects the addressed byte/half of a read word and sign/zero-extends it.
// Latency: combinational. Backpressure: none.
// Ports: rdata (read word), off (byte offset), funct3 (access type) -> result (32-bit extended value).
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Halves only look at off[1]; a set off[0] is either trapped upstream or ignored.
  assign byte_v = rdata[{off, 3'b000} +: 8];
  assign half_v = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    result = 32'd0;
    case (funct3)
      MEM_FUNCT3_B:  result = {{24{byte_v[7]}}, byte_v};
      MEM_FUNCT3_BU: result = {24'd0, byte_v};
      MEM_FUNCT3_H:  result = {{16{half_v[15]}}, half_v};
      MEM_FUNCT3_HU: result = {16'd0, half_v};
      MEM_FUNCT3_W:  result = rdata;
      default:       result = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store per request handshake, word-aligned dmem port, extended load result.
// Latency: 3 cycles accept->resp_valid with a zero-wait memory; faults respond 1 cycle after accept.
// Backpressure: req_ready only in IDLE; request held until dmem_req_ready; WAIT bounded by RESP_TIMEOUT.
// Ports: req_valid/req_ready/mem_wen/mem_funct3/addr/wdata (request), resp_valid/mem_output/bus_err/misalign
//        (response), dmem_* (memory side). Optional LSU_MISALIGN_CHECK_EN traps misaligned H/W accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_wen,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] mem_output,
  output logic        bus_err,
  output logic        misalign,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  lsu_state_t  state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [8:0]  wait_cnt_inc;
  logic        timeout_hit;
  logic        fault_illegal, fault_misalign, req_fault;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;
  logic [31:0] load_result;

  assign wait_cnt_inc  = {1'b0, wait_cnt} + 9'd1;
  assign timeout_hit   = (wait_cnt_inc == 9'(RESP_TIMEOUT));
  assign fault_illegal = !funct3_legal(mem_wen, mem_funct3);
`ifdef LSU_MISALIGN_CHECK_EN
  assign fault_misalign = access_misaligned(mem_funct3, addr[1:0]);
`else
  assign fault_misalign = 1'b0;
`endif
  assign req_fault = fault_illegal | fault_misalign;

  // Store lanes are formed at accept time so the memory sees stable, pre-shifted fields.
  always_comb begin
    st_wmask = 4'b0000;
    st_wdata = 32'd0;
    if (mem_wen) begin
      case (mem_funct3)
        MEM_FUNCT3_B: begin
          st_wmask = 4'b0001 << addr[1:0];
          st_wdata = {4{wdata[7:0]}};
        end
        MEM_FUNCT3_H: begin
          st_wmask = 4'b0011 << {addr[1], 1'b0};
          st_wdata = {2{wdata[15:0]}};
        end
        MEM_FUNCT3_W: begin
          st_wmask = 4'hF;
          st_wdata = wdata;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    dmem_req_valid = 1'b0;
    resp_valid     = 1'b0;
    case (state)
      LSU_IDLE: begin
        // Gated by rst so every output reads 0 while reset is held.
        req_ready = !rst;
        if (req_valid) state_nxt = req_fault ? LSU_RESP : LSU_REQ;
      end
      LSU_REQ: begin
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) state_nxt = LSU_WAIT;
      end
      LSU_WAIT: begin
        if (dmem_rvalid || timeout_hit) state_nxt = LSU_RESP;
      end
      LSU_RESP: begin
        resp_valid = 1'b1;
        state_nxt  = LSU_IDLE;
      end
      default: state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_addr  <= 32'd0;
      dmem_wen   <= 1'b0;
      dmem_wmask <= 4'd0;
      dmem_wdata <= 32'd0;
      off_q      <= 2'd0;
      funct3_q   <= 3'd0;
      wait_cnt   <= 8'd0;
      mem_output <= 32'd0;
      bus_err    <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_wen   <= mem_wen;
            dmem_wmask <= st_wmask;
            dmem_wdata <= st_wdata;
            off_q      <= addr[1:0];
            funct3_q   <= mem_funct3;
            if (req_fault) begin
              mem_output <= 32'd0;
              bus_err    <= fault_illegal;
              misalign   <= fault_misalign;
            end
          end
        end
        LSU_REQ: begin
          if (dmem_req_ready) wait_cnt <= 8'd0;
        end
        LSU_WAIT: begin
          wait_cnt <= wait_cnt_inc[7:0];
          // rvalid has priority over a timeout landing in the same cycle.
          if (dmem_rvalid) begin
            mem_output <= dmem_wen ? 32'd0 : load_result;
            bus_err    <= 1'b0;
            misalign   <= 1'b0;
          end else if (timeout_hit) begin
            mem_output <= 32'd0;
            bus_err    <= 1'b1;
            misalign   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  load_extend u_load_extend (
    .rdata  (dmem_rdata),
    .off    (off_q),
    .funct3 (funct3_q),
    .result (load_result)
  );

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_wen = 1'b0;
  logic [2:0]  mem_funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] mem_output;
  logic        bus_err;
  logic        misalign;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_addr;
  logic        dmem_wen;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  load_store_unit #(.RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_wen(mem_wen), .mem_funct3(mem_funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .mem_output(mem_output), .bus_err(bus_err), .misalign(misalign),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
    .dmem_wen(dmem_wen), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] data;
    logic        berr;
    logic        mis;
  } exp_t;

  exp_t  exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    resp_cnt = 0;
  int    resp_cyc = 0;
  string cur_name = "reset";

  task automatic check(input string name, input string what, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s_%s: got %h want %h", name, what, act, req);
    end
  endtask

  // Scoreboard monitor: every response pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        resp_cnt++;
        resp_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL %s_unexpected_resp: got resp_valid=1 want none", cur_name);
        end else begin
          e = exp_q.pop_front();
          check(cur_name, "data", {32'd0, mem_output}, {32'd0, e.data});
          check(cur_name, "err", {62'd0, bus_err, misalign}, {62'd0, e.berr, e.mis});
        end
      end
    end
  end

  task automatic access(input string name, input logic wen, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int rdy_lat, input int rv_lat, input logic fault,
                        input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_out,
                        input logic exp_berr, input logic exp_mis, input int exp_lat);
    int acc_cyc, hs_cyc, n0, k;
    logic saw_req, stall_bad;
    logic [68:0] snap;
    cur_name = name;
    exp_q.push_back(exp_t'{exp_out, exp_berr, exp_mis});
    n0 = resp_cnt;
    hs_cyc = 0;
    @(negedge clk);
    check(name, "req_ready", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; mem_wen = wen; mem_funct3 = f3; addr = a; wdata = wd;
    acc_cyc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (fault) begin
      saw_req = 1'b0;
      k = 0;
      while (resp_cnt == n0 && k < 20) begin
        @(negedge clk); #1;
        if (dmem_req_valid !== 1'b0) saw_req = 1'b1;
        k++;
      end
      check(name, "no_dmem_req", {63'd0, saw_req}, 64'd0);
    end else begin
      @(negedge clk);
      check(name, "dmem_req_valid", {63'd0, dmem_req_valid}, 64'd1);
      check(name, "fields", {27'd0, dmem_addr, dmem_wen, dmem_wmask}, {27'd0, exp_addr, wen, exp_mask});
      if (wen) check(name, "wdata", {32'd0, dmem_wdata}, {32'd0, exp_wdata});
      snap = {dmem_addr, dmem_wen, dmem_wmask, dmem_wdata};
      stall_bad = 1'b0;
      for (int i = 0; i < rdy_lat; i++) begin
        @(posedge clk); @(negedge clk);
        if (dmem_req_valid !== 1'b1 || {dmem_addr, dmem_wen, dmem_wmask, dmem_wdata} !== snap)
          stall_bad = 1'b1;
      end
      if (rdy_lat > 0) check(name, "stall_stable", {63'd0, stall_bad}, 64'd0);
      dmem_req_ready = 1'b1;
      @(posedge clk);
      #1 dmem_req_ready = 1'b0;
      hs_cyc = cyc;
      if (rv_lat >= 0) begin
        for (int i = 0; i < rv_lat; i++) begin
          @(posedge clk); #1;
        end
        dmem_rvalid = 1'b1; dmem_rdata = rd;
        @(posedge clk);
        #1 dmem_rvalid = 1'b0;
      end
    end
    k = 0;
    while (resp_cnt == n0 && k < TO + 50) begin
      @(negedge clk); #1;
      k++;
    end
    if (resp_cnt == n0) begin
      total++;
      bad++;
      $display("FAIL %s_resp_timeout: got no resp_valid want one", name);
      void'(exp_q.pop_front());
    end else begin
      check(name, "latency", 64'(resp_cyc - acc_cyc), 64'(exp_lat));
      if (!fault && rv_lat < 0) check(name, "wait_cycles", 64'(resp_cyc - hs_cyc), 64'(TO));
      @(negedge clk); #1;
      check(name, "resp_pulse_ready", {62'd0, resp_valid, req_ready}, 64'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  initial begin
    int n0;
    repeat (2) @(negedge clk);
    check("reset", "outputs", {25'd0, req_ready, resp_valid, dmem_req_valid, dmem_wen, dmem_wmask, bus_err, misalign,
                               mem_output | dmem_addr | dmem_wdata}, 64'd0);
    rst = 1'b0;
    #1 check("reset", "req_ready_after", {63'd0, req_ready}, 64'd1);

    // name wen f3 addr wdata rdata rdy rv fault exp_addr mask exp_wdata out berr mis lat
    access("lw",    0, 3'b010, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 32'h8000_0004, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, 3);
    access("lb",    0, 3'b000, 32'h8000_0003, 32'h0,        32'h80FF_7F01, 0, 0, 0, 32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_FF80, 0, 0, 3);
    access("lbu",   0, 3'b100, 32'h8000_0003, 32'h0,        32'h80FF_7F01, 0, 0, 0, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_0080, 0, 0, 3);
    access("lhu",   0, 3'b101, 32'h8000_0002, 32'h0,        32'h80FF_7F01, 0, 0, 0, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_80FF, 0, 0, 3);
    access("lh2",   0, 3'b001, 32'h8000_0002, 32'h0,        32'h80FF_7F01, 0, 0, 0, 32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_80FF, 0, 0, 3);
    access("lh0",   0, 3'b001, 32'h8000_0000, 32'h0,        32'h80FF_7F01, 0, 0, 0, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_7F01, 0, 0, 3);
    access("lb1",   0, 3'b000, 32'h8000_0001, 32'h0,        32'h80FF_7F01, 0, 0, 0, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_007F, 0, 0, 3);
    access("lbu0",  0, 3'b100, 32'h8000_0000, 32'h0,        32'h80FF_7F01, 0, 0, 0, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_0001, 0, 0, 3);
    access("sb2",   1, 3'b000, 32'h8000_0002, 32'h0000_00AB, 32'h0,        0, 0, 0, 32'h8000_0000, 4'b0100, 32'hABAB_ABAB, 32'h0, 0, 0, 3);
    access("sb1",   1, 3'b000, 32'h8000_0001, 32'h0000_115A, 32'h0,        0, 0, 0, 32'h8000_0000, 4'b0010, 32'h5A5A_5A5A, 32'h0, 0, 0, 3);
    access("sh2",   1, 3'b001, 32'h8000_0002, 32'h0000_1234, 32'h0,        0, 0, 0, 32'h8000_0000, 4'b1100, 32'h1234_1234, 32'h0, 0, 0, 3);
    access("sw",    1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0,        0, 0, 0, 32'h8000_0008, 4'hF,    32'hCAFE_F00D, 32'h0, 0, 0, 3);
    access("illeg", 0, 3'b011, 32'h8000_0000, 32'h0,        32'h0,         0, 0, 1, 32'h0,         4'h0, 32'h0, 32'h0, 1, 0, 1);
    access("slow",  0, 3'b010, 32'h8000_000C, 32'h0,        32'h0BAD_F00D, 2, 4, 0, 32'h8000_000C, 4'h0, 32'h0, 32'h0BAD_F00D, 0, 0, 9);
    access("tmo",   0, 3'b010, 32'h8000_0010, 32'h0,        32'h0,         5, -1, 0, 32'h8000_0010, 4'h0, 32'h0, 32'h0, 1, 0, 2 + 5 + TO);
`ifdef LSU_MISALIGN_CHECK_EN
    access("lw_mis", 0, 3'b010, 32'h8000_0002, 32'h0,       32'h1122_3344, 0, 0, 1, 32'h0,         4'h0, 32'h0, 32'h0, 0, 1, 1);
`else
    access("lw_mis", 0, 3'b010, 32'h8000_0002, 32'h0,       32'h1122_3344, 0, 0, 0, 32'h8000_0000, 4'h0, 32'h0, 32'h1122_3344, 0, 0, 3);
`endif
    access("lhu_pre", 0, 3'b101, 32'h8000_0012, 32'h0,      32'hA5A5_0000, 0, 0, 0, 32'h8000_0010, 4'h0, 32'h0, 32'h0000_A5A5, 0, 0, 3);

    // Reset in WAIT, then a stray rvalid after release.
    cur_name = "rst_wait";
    n0 = resp_cnt;
    @(negedge clk);
    req_valid = 1'b1; mem_wen = 1'b0; mem_funct3 = 3'b010; addr = 32'h8000_0020;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    dmem_req_ready = 1'b1;
    @(posedge clk);
    #1 dmem_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_wait", "outputs", {25'd0, req_ready, resp_valid, dmem_req_valid, dmem_wen, dmem_wmask, bus_err, misalign,
                                     mem_output | dmem_addr | dmem_wdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_wait", "req_ready_after", {63'd0, req_ready}, 64'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1 dmem_rvalid = 1'b0;
    repeat (5) @(negedge clk);
    #1 check("rst_wait", "no_resp", 64'(resp_cnt - n0), 64'd0);
    check("rst_wait", "mem_output", {32'd0, mem_output}, 64'd0);

    access("recover", 0, 3'b010, 32'h8000_0024, 32'h0, 32'h7654_3210, 0, 0, 0, 32'h8000_0024, 4'h0, 32'h0, 32'h7654_3210, 0, 0, 3);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
